// File: rtl/execute_stage.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, branch/jump resolution
// and the EX/MEM pipeline register feeding the Memory stage.
module execute_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            FlushE,
   input  logic            RegWriteE,
   input  logic [1:0]      ResultSrcE,
   input  logic            MemWriteE,
   input  logic            JumpE,
   input  logic            JalrE,
   input  logic            BranchE,
   input  logic            ALUSrcE,
   input  logic [3:0]      ALUControlE,
   input  logic [2:0]      Funct3E,
   input  logic [XLEN-1:0] RD1_E,
   input  logic [XLEN-1:0] RD2_E,
   input  logic [XLEN-1:0] Imm_Ext_E,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [4:0]      RD_E,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] ResultW,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            RegWriteM,
   output logic [1:0]      ResultSrcM,
   output logic            MemWriteM,
   output logic [4:0]      RD_M,
   output logic [XLEN-1:0] ALU_ResultM,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] PCPlus4M
);

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;

   localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};

   // Select 11 is unused by the hazard unit and falls back to the register-file value.
   function automatic logic [XLEN-1:0] fwd_mux(
      input logic [1:0]      sel,
      input logic [XLEN-1:0] reg_val,
      input logic [XLEN-1:0] w_val,
      input logic [XLEN-1:0] m_val
   );
      logic [XLEN-1:0] res;
      case (sel)
         2'b01:   res = w_val;
         2'b10:   res = m_val;
         default: res = reg_val;
      endcase
      return res;
   endfunction

   function automatic logic [XLEN-1:0] alu_op(
      input logic [3:0]      ctrl,
      input logic [XLEN-1:0] a,
      input logic [XLEN-1:0] b
   );
      logic [XLEN-1:0] res;
      logic [4:0]      shamt;
      shamt = b[4:0];
      case (ctrl)
         ALU_ADD:  res = a + b;
         ALU_SUB:  res = a - b;
         ALU_AND:  res = a & b;
         ALU_OR:   res = a | b;
         ALU_XOR:  res = a ^ b;
         ALU_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
         ALU_SLL:  res = a << shamt;
         ALU_SRL:  res = a >> shamt;
         ALU_SRA:  res = $unsigned($signed(a) >>> shamt);
         default:  res = ZERO;
      endcase
      return res;
   endfunction

   function automatic logic branch_taken(
      input logic [2:0]      f3,
      input logic [XLEN-1:0] a,
      input logic [XLEN-1:0] b
   );
      logic res;
      case (f3)
         BR_EQ:   res = (a == b);
         BR_NE:   res = (a != b);
         BR_LT:   res = ($signed(a) < $signed(b));
         BR_GE:   res = ($signed(a) >= $signed(b));
         BR_LTU:  res = (a < b);
         BR_GEU:  res = (a >= b);
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   logic [XLEN-1:0] src_a_s;
   logic [XLEN-1:0] fwd_b_s;
   logic [XLEN-1:0] src_b_s;
   logic [XLEN-1:0] alu_result_s;
   logic [XLEN-1:0] jalr_sum_s;
   logic            taken_s;

   // Forwarding, ALU and redirect resolution; the M forward source is the pre-edge register.
   always_comb begin
      src_a_s      = fwd_mux(ForwardAE, RD1_E, ResultW, ALU_ResultM);
      fwd_b_s      = fwd_mux(ForwardBE, RD2_E, ResultW, ALU_ResultM);
      src_b_s      = fwd_b_s;
      if (ALUSrcE) begin
         src_b_s = Imm_Ext_E;
      end else begin
         src_b_s = fwd_b_s;
      end
      alu_result_s = alu_op(ALUControlE, src_a_s, src_b_s);
      taken_s      = branch_taken(Funct3E, src_a_s, fwd_b_s);
      jalr_sum_s   = src_a_s + Imm_Ext_E;
      PCSrcE       = (BranchE & taken_s) | JumpE | JalrE;
      PCTargetE    = PCE + Imm_Ext_E;
      if (JalrE) begin
         PCTargetE = {jalr_sum_s[XLEN-1:1], 1'b0};
      end else begin
         PCTargetE = PCE + Imm_Ext_E;
      end
   end

   // EX/MEM pipeline register; a flush turns the instruction into a bubble but still loads data.
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWriteM   <= 1'b0;
         ResultSrcM  <= 2'b00;
         MemWriteM   <= 1'b0;
         RD_M        <= 5'd0;
         ALU_ResultM <= ZERO;
         WriteDataM  <= ZERO;
         PCPlus4M    <= ZERO;
      end else if (FlushE) begin
         RegWriteM   <= 1'b0;
         ResultSrcM  <= 2'b00;
         MemWriteM   <= 1'b0;
         RD_M        <= 5'd0;
         ALU_ResultM <= alu_result_s;
         WriteDataM  <= fwd_b_s;
         PCPlus4M    <= PCPlus4E;
      end else begin
         RegWriteM   <= RegWriteE;
         ResultSrcM  <= ResultSrcE;
         MemWriteM   <= MemWriteE;
         RD_M        <= RD_E;
         ALU_ResultM <= alu_result_s;
         WriteDataM  <= fwd_b_s;
         PCPlus4M    <= PCPlus4E;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: table-driven ALU/branch/jump vectors plus
// hand-written reset, back-to-back forwarding and flush sequences.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        FlushE;
   logic        RegWriteE;
   logic [1:0]  ResultSrcE;
   logic        MemWriteE;
   logic        JumpE;
   logic        JalrE;
   logic        BranchE;
   logic        ALUSrcE;
   logic [3:0]  ALUControlE;
   logic [2:0]  Funct3E;
   logic [31:0] RD1_E;
   logic [31:0] RD2_E;
   logic [31:0] Imm_Ext_E;
   logic [31:0] PCE;
   logic [31:0] PCPlus4E;
   logic [4:0]  RD_E;
   logic [1:0]  ForwardAE;
   logic [1:0]  ForwardBE;
   logic [31:0] ResultW;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        RegWriteM;
   logic [1:0]  ResultSrcM;
   logic        MemWriteM;
   logic [4:0]  RD_M;
   logic [31:0] ALU_ResultM;
   logic [31:0] WriteDataM;
   logic [31:0] PCPlus4M;

   int n_checks = 0;
   int n_fail   = 0;

   execute_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .FlushE(FlushE), .RegWriteE(RegWriteE),
      .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .JumpE(JumpE), .JalrE(JalrE),
      .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .Funct3E(Funct3E),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
      .RD_E(RD_E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
      .MemWriteM(MemWriteM), .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
      .PCPlus4M(PCPlus4M)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  ctrl;
      logic        alusrc;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] resw;
      logic        branch;
      logic [2:0]  f3;
      logic        jump;
      logic        jalr;
      logic [31:0] exp_alu;
      logic [31:0] exp_wd;
      logic        exp_pcsrc;
      logic [31:0] exp_target;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic [3:0] ctrl, input logic alusrc, input logic [1:0] fa, input logic [1:0] fb,
      input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
      input logic [31:0] resw, input logic branch, input logic [2:0] f3,
      input logic jump, input logic jalr, input logic [31:0] exp_alu,
      input logic [31:0] exp_wd, input logic exp_pcsrc, input logic [31:0] exp_target
   );
      vec_t v;
      v.ctrl = ctrl; v.alusrc = alusrc; v.fa = fa; v.fb = fb;
      v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.resw = resw;
      v.branch = branch; v.f3 = f3; v.jump = jump; v.jalr = jalr;
      v.exp_alu = exp_alu; v.exp_wd = exp_wd; v.exp_pcsrc = exp_pcsrc; v.exp_target = exp_target;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      rst = 1'b0; FlushE = 1'b0; RegWriteE = 1'b0; ResultSrcE = 2'b00; MemWriteE = 1'b0;
      JumpE = 1'b0; JalrE = 1'b0; BranchE = 1'b0; ALUSrcE = 1'b0; ALUControlE = 4'd0;
      Funct3E = 3'd0; RD1_E = 32'd0; RD2_E = 32'd0; Imm_Ext_E = 32'd0; PCE = 32'h100;
      PCPlus4E = 32'h104; RD_E = 5'd0; ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 32'd0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " RegWriteM"},   {31'd0, RegWriteM}, 32'd0);
      chk({tag, " MemWriteM"},   {31'd0, MemWriteM}, 32'd0);
      chk({tag, " ResultSrcM"},  {30'd0, ResultSrcM}, 32'd0);
      chk({tag, " RD_M"},        {27'd0, RD_M}, 32'd0);
      chk({tag, " ALU_ResultM"}, ALU_ResultM, 32'd0);
      chk({tag, " WriteDataM"},  WriteDataM, 32'd0);
      chk({tag, " PCPlus4M"},    PCPlus4M, 32'd0);
   endtask

   initial begin
      // ALU sweep: SrcA=0x80000000, SrcB=imm=1, rs2 value 0x55, PC 0x100
      vecs.push_back(mk(4'b0000,1'b1,2'b00,2'b00,32'h80000000,32'h55,32'h1,32'h0,1'b0,3'b000,1'b0,1'b0,32'h80000001,32'h55,1'b0,32'h101));
      vecs.push_back(mk(4'b0001,1'b1,2'b00,2'b00,32'h80000000,32'h55,32'h1,32'h0,1'b0,3'b000,1'b0,1'b0,32'h7FFFFFFF,32'h55,1'b0,32'h101));
      vecs.push_back(mk(4'b0010,1'b1,2'b00,2'b00,32'h80000000,32'h55,32'h1,32'h0,1'b0,3'b000,1'b0,1'b0,32'h00000000,32'h55,1'b0,32'h101));
      vecs.push_back(mk(4'b0011,1'b1,2'b00,2'b00,32'h80000000,32'h55,32'h1,32'h0,1'b0,3'b000,1'b0,1'b0,32'h80000001,32'h55,1'b0,32'h101));
      vecs.push_back(mk(4'b0100,1'b1,2'b00,2'b00,32'h80000000,32'h55,32'h1,32'h0,1'b0,3'b000,1'b0,1'b0,32'h80000001,32'h55,1'b0,32'h101));
      vecs.push_back(mk(4'b0101,1'b1,2'b00,2'b00,32'h80000000,32'h55,32'h1,32'h0,1'b0,3'b000,1'b0,1'b0,32'h00000001,32'h55,1'b0,32'h101));
      vecs.push_back(mk(4'b0110,1'b1,2'b00,2'b00,32'h80000000,32'h55,32'h1,32'h0,1'b0,3'b000,1'b0,1'b0,32'h00000000,32'h55,1'b0,32'h101));
      vecs.push_back(mk(4'b0111,1'b1,2'b00,2'b00,32'h80000000,32'h55,32'h1,32'h0,1'b0,3'b000,1'b0,1'b0,32'h00000000,32'h55,1'b0,32'h101));
      vecs.push_back(mk(4'b1000,1'b1,2'b00,2'b00,32'h80000000,32'h55,32'h1,32'h0,1'b0,3'b000,1'b0,1'b0,32'h40000000,32'h55,1'b0,32'h101));
      vecs.push_back(mk(4'b1001,1'b1,2'b00,2'b00,32'h80000000,32'h55,32'h1,32'h0,1'b0,3'b000,1'b0,1'b0,32'hC0000000,32'h55,1'b0,32'h101));
      vecs.push_back(mk(4'b1010,1'b1,2'b00,2'b00,32'h80000000,32'h55,32'h1,32'h0,1'b0,3'b000,1'b0,1'b0,32'h00000000,32'h55,1'b0,32'h101));
      vecs.push_back(mk(4'b1111,1'b1,2'b00,2'b00,32'h80000000,32'h55,32'h1,32'h0,1'b0,3'b000,1'b0,1'b0,32'h00000000,32'h55,1'b0,32'h101));
      // shift amount uses only SrcB[4:0]; add wraps
      vecs.push_back(mk(4'b0111,1'b1,2'b00,2'b00,32'h1,32'h0,32'h21,32'h0,1'b0,3'b000,1'b0,1'b0,32'h2,32'h0,1'b0,32'h121));
      vecs.push_back(mk(4'b0000,1'b0,2'b00,2'b00,32'hFFFFFFFF,32'h1,32'h0,32'h0,1'b0,3'b000,1'b0,1'b0,32'h0,32'h1,1'b0,32'h100));
      // branches: A=-1, B=1, target 0x100+0x40
      vecs.push_back(mk(4'b0000,1'b0,2'b00,2'b00,32'hFFFFFFFF,32'h1,32'h40,32'h0,1'b1,3'b100,1'b0,1'b0,32'h0,32'h1,1'b1,32'h140));
      vecs.push_back(mk(4'b0000,1'b0,2'b00,2'b00,32'hFFFFFFFF,32'h1,32'h40,32'h0,1'b1,3'b110,1'b0,1'b0,32'h0,32'h1,1'b0,32'h140));
      vecs.push_back(mk(4'b0000,1'b0,2'b00,2'b00,32'hFFFFFFFF,32'h1,32'h40,32'h0,1'b1,3'b101,1'b0,1'b0,32'h0,32'h1,1'b0,32'h140));
      vecs.push_back(mk(4'b0000,1'b0,2'b00,2'b00,32'hFFFFFFFF,32'h1,32'h40,32'h0,1'b1,3'b111,1'b0,1'b0,32'h0,32'h1,1'b1,32'h140));
      vecs.push_back(mk(4'b0000,1'b0,2'b00,2'b00,32'hFFFFFFFF,32'h1,32'h40,32'h0,1'b1,3'b000,1'b0,1'b0,32'h0,32'h1,1'b0,32'h140));
      vecs.push_back(mk(4'b0000,1'b0,2'b00,2'b00,32'hFFFFFFFF,32'h1,32'h40,32'h0,1'b1,3'b001,1'b0,1'b0,32'h0,32'h1,1'b1,32'h140));
      vecs.push_back(mk(4'b0000,1'b0,2'b00,2'b00,32'h5,32'h5,32'h40,32'h0,1'b1,3'b000,1'b0,1'b0,32'hA,32'h5,1'b1,32'h140));
      vecs.push_back(mk(4'b0000,1'b0,2'b00,2'b00,32'h5,32'h5,32'h40,32'h0,1'b1,3'b010,1'b0,1'b0,32'hA,32'h5,1'b0,32'h140));
      vecs.push_back(mk(4'b0000,1'b0,2'b00,2'b00,32'h5,32'h5,32'h40,32'h0,1'b1,3'b011,1'b0,1'b0,32'hA,32'h5,1'b0,32'h140));
      vecs.push_back(mk(4'b0000,1'b0,2'b00,2'b00,32'h5,32'h6,32'h40,32'h0,1'b0,3'b001,1'b0,1'b0,32'hB,32'h6,1'b0,32'h140));
      // JAL, JALR, and both set (JALR target wins)
      vecs.push_back(mk(4'b0000,1'b1,2'b00,2'b00,32'h0,32'h0,32'h10,32'h0,1'b0,3'b000,1'b1,1'b0,32'h10,32'h0,1'b1,32'h110));
      vecs.push_back(mk(4'b0000,1'b1,2'b00,2'b00,32'h1001,32'h0,32'h2,32'h0,1'b0,3'b000,1'b0,1'b1,32'h1003,32'h0,1'b1,32'h1002));
      vecs.push_back(mk(4'b0000,1'b1,2'b00,2'b00,32'h1001,32'h0,32'h2,32'h0,1'b0,3'b000,1'b1,1'b1,32'h1003,32'h0,1'b1,32'h1002));
      // forwarding from W, and select 11 behaving as 00
      vecs.push_back(mk(4'b0000,1'b1,2'b01,2'b00,32'h999,32'h22,32'h1,32'h10,1'b0,3'b000,1'b0,1'b0,32'h11,32'h22,1'b0,32'h101));
      vecs.push_back(mk(4'b0000,1'b0,2'b00,2'b01,32'h3,32'h22,32'h1,32'h10,1'b0,3'b000,1'b0,1'b0,32'h13,32'h10,1'b0,32'h101));
      vecs.push_back(mk(4'b0000,1'b1,2'b11,2'b11,32'h7,32'h33,32'h1,32'h10,1'b0,3'b000,1'b0,1'b0,32'h8,32'h33,1'b0,32'h101));

      // Reset held two cycles with random inputs
      clear_inputs();
      rst = 1'b1; FlushE = 1'($urandom); RegWriteE = 1'b1; MemWriteE = 1'b1;
      ResultSrcE = 2'($urandom); RD_E = 5'($urandom_range(31, 1)); RD1_E = $urandom;
      RD2_E = $urandom; Imm_Ext_E = $urandom; PCPlus4E = $urandom | 32'h4;
      ALUControlE = 4'($urandom); ResultW = $urandom;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         chk_all_zero("reset");
      end

      // Table-driven vectors
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         clear_inputs();
         ALUControlE = vecs[i].ctrl; ALUSrcE = vecs[i].alusrc;
         ForwardAE = vecs[i].fa; ForwardBE = vecs[i].fb;
         RD1_E = vecs[i].rd1; RD2_E = vecs[i].rd2; Imm_Ext_E = vecs[i].imm;
         ResultW = vecs[i].resw; BranchE = vecs[i].branch; Funct3E = vecs[i].f3;
         JumpE = vecs[i].jump; JalrE = vecs[i].jalr;
         RegWriteE = 1'b1; RD_E = 5'(i + 1); PCPlus4E = 32'h104 + 32'(i);
         #1;
         chk($sformatf("v%0d PCSrcE", i), {31'd0, PCSrcE}, {31'd0, vecs[i].exp_pcsrc});
         chk($sformatf("v%0d PCTargetE", i), PCTargetE, vecs[i].exp_target);
         @(posedge clk); #1;
         chk($sformatf("v%0d ALU_ResultM", i), ALU_ResultM, vecs[i].exp_alu);
         chk($sformatf("v%0d WriteDataM", i), WriteDataM, vecs[i].exp_wd);
         chk($sformatf("v%0d PCPlus4M", i), PCPlus4M, 32'h104 + 32'(i));
         chk($sformatf("v%0d RD_M", i), {27'd0, RD_M}, 32'(i + 1));
         chk($sformatf("v%0d RegWriteM", i), {31'd0, RegWriteM}, 32'd1);
      end

      // Back-to-back forwarding: add x5 = 3 + 4
      @(negedge clk);
      clear_inputs();
      RD1_E = 32'd3; RD2_E = 32'd4; RD_E = 5'd5; RegWriteE = 1'b1;
      ResultSrcE = 2'b01; MemWriteE = 1'b1;
      @(posedge clk); #1;
      chk("b2b add ALU_ResultM", ALU_ResultM, 32'd7);
      chk("b2b ResultSrcM", {30'd0, ResultSrcM}, 32'd1);
      chk("b2b MemWriteM", {31'd0, MemWriteM}, 32'd1);
      @(negedge clk);
      clear_inputs();
      ForwardAE = 2'b10; RD1_E = 32'hDEAD; RD2_E = 32'd1; ALUControlE = 4'b0001; RD_E = 5'd6;
      @(posedge clk); #1;
      chk("b2b sub ALU_ResultM", ALU_ResultM, 32'd6);
      @(negedge clk);
      clear_inputs();
      ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h10; RD2_E = 32'h77; ALUControlE = 4'b0001;
      @(posedge clk); #1;
      chk("b2b fwdB WriteDataM", WriteDataM, 32'h10);
      chk("b2b fwdB ALU_ResultM", ALU_ResultM, 32'hFFFFFFF6);

      // Flush: control cleared, data loaded, redirect not suppressed
      @(negedge clk);
      clear_inputs();
      FlushE = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 2'b10; RD_E = 5'd7;
      RD1_E = 32'd5; RD2_E = 32'd6; JumpE = 1'b1; PCPlus4E = 32'h204;
      #1;
      chk("flush PCSrcE", {31'd0, PCSrcE}, 32'd1);
      @(posedge clk); #1;
      chk("flush RegWriteM", {31'd0, RegWriteM}, 32'd0);
      chk("flush MemWriteM", {31'd0, MemWriteM}, 32'd0);
      chk("flush ResultSrcM", {30'd0, ResultSrcM}, 32'd0);
      chk("flush RD_M", {27'd0, RD_M}, 32'd0);
      chk("flush ALU_ResultM", ALU_ResultM, 32'd11);
      chk("flush WriteDataM", WriteDataM, 32'd6);
      chk("flush PCPlus4M", PCPlus4M, 32'h204);

      // Flush and reset together after a live instruction: everything zero
      @(negedge clk);
      clear_inputs();
      RegWriteE = 1'b1; RD_E = 5'd9; RD1_E = 32'h123; PCPlus4E = 32'h304;
      @(posedge clk); #1;
      chk("pre-reset RD_M", {27'd0, RD_M}, 32'd9);
      @(negedge clk);
      rst = 1'b1; FlushE = 1'b1; MemWriteE = 1'b1;
      @(posedge clk); #1;
      chk_all_zero("rst+flush");
      @(negedge clk);
      clear_inputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
